// File: rtl/sync_fifo_wr_arb.sv
// Round-robin write arbiter that shares one sync_fifo write port among NUM_REQ producers.
// Grants are burst-locked (up to MAX_BURST beats) and withheld while the FIFO is almost full.
//
//   state    | meaning
//   ST_IDLE  | no grant; pick the next producer when one is valid and the FIFO is not almost full
//   ST_BURST | forward beats of producer gnt_q until last, forced release, or withdraw
module sync_fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int IW         = $clog2(NUM_REQ),
    parameter int CW         = $clog2(MAX_BURST + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]            i_req_last,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_fifo_ready,
    input  logic                          i_fifo_almostfull,
    output logic                          o_fifo_valid,
    output logic [DATA_WIDTH-1:0]         o_fifo_data,
    output logic [IW-1:0]                 o_grant_id,
    output logic                          o_busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   last_gnt_q, last_gnt_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [IW-1:0]   winner;
    logic [IW-1:0]   cand;
    logic            found;

    // Scan last_gnt+1, last_gnt+2, ... so the most recent grantee has lowest priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(last_gnt_q) + i) % NUM_REQ);
            if (!found && i_req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_gnt_d   = last_gnt_q;
        beat_cnt_d   = beat_cnt_q;
        o_fifo_valid = 1'b0;
        o_fifo_data  = '0;
        o_req_ready  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (found && !i_fifo_almostfull) begin
                    gnt_d      = winner;
                    beat_cnt_d = '0;
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                o_fifo_valid       = i_req_valid[gnt_q];
                o_fifo_data        = i_req_data[gnt_q*DATA_WIDTH +: DATA_WIDTH];
                o_req_ready[gnt_q] = i_fifo_ready;
                if (!i_req_valid[gnt_q]) begin
                    state_d    = ST_IDLE;
                    last_gnt_d = gnt_q;
                end else if (i_fifo_ready) begin
                    // Counter is held on the closing beat so it never exceeds MAX_BURST-1.
                    if (i_req_last[gnt_q] || (beat_cnt_q == CW'(MAX_BURST - 1))) begin
                        state_d    = ST_IDLE;
                        last_gnt_d = gnt_q;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            last_gnt_q <= IW'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign o_busy     = (state_q == ST_BURST);
    assign o_grant_id = gnt_q;

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Directed bench for sync_fifo_wr_arb: simple producer models, a write log of
// accepted FIFO beats, and hand-computed expectations per scenario.
module tb_sync_fifo_wr_arb;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              fifo_ready;
    logic              fifo_af;
    logic              fifo_valid;
    logic [DW-1:0]     fifo_data;
    logic [1:0]        grant_id;
    logic              busy;

    logic [NR-1:0]     p_en;
    int                p_len  [NR];
    int                p_beat [NR];
    logic [DW-1:0]     wr_q[$];

    int total = 0;
    int bad   = 0;
    int base;

    sync_fifo_wr_arb #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_req_valid       (req_valid),
        .i_req_data        (req_data),
        .i_req_last        (req_last),
        .o_req_ready       (req_ready),
        .i_fifo_ready      (fifo_ready),
        .i_fifo_almostfull (fifo_af),
        .o_fifo_valid      (fifo_valid),
        .o_fifo_data       (fifo_data),
        .o_grant_id        (grant_id),
        .o_busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Producer k emits {k+1, beat index}; last every p_len beats (0 = never).
    always_comb begin
        req_valid = p_en;
        req_data  = '0;
        req_last  = '0;
        for (int k = 0; k < NR; k++) begin
            req_data[k*DW +: DW] = {8'(k + 1), 24'(p_beat[k])};
            req_last[k] = (p_len[k] != 0) && (((p_beat[k] + 1) % p_len[k]) == 0);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NR; k++) p_beat[k] <= 0;
        end else begin
            for (int k = 0; k < NR; k++)
                if (req_valid[k] && req_ready[k]) p_beat[k] <= p_beat[k] + 1;
        end
    end

    always @(posedge clk)
        if (rst_n && fifo_valid && fifo_ready) wr_q.push_back(fifo_data);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        p_en       = '0;
        fifo_ready = 1'b1;
        fifo_af    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NR; k++) p_len[k] = 0;
        do_reset();

        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_gid",   64'(grant_id), 64'd0);
        chk("rst_valid", 64'(fifo_valid), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_data",  64'(fifo_data), 64'd0);

        // Reset priority: producers 0 and 2, one-beat bursts.
        p_len[0] = 1; p_len[2] = 1;
        p_en = 4'b0101;
        base = wr_q.size();
        #1 chk("rp_idle_valid", 64'(fifo_valid), 64'd0);
        tick();
        chk("rp_g0_busy",  64'(busy), 64'd1);
        chk("rp_g0_gid",   64'(grant_id), 64'd0);
        chk("rp_g0_ready", 64'(req_ready), 64'b0001);
        chk("rp_g0_data",  64'(fifo_data), 64'h0100_0000);
        tick();
        chk("rp_bubble",   64'(busy), 64'd0);
        chk("rp_wr1",      64'(wr_q.size() - base), 64'd1);
        chk("rp_wr1_data", 64'(wr_q[base]), 64'h0100_0000);
        tick();
        chk("rp_g2_gid",   64'(grant_id), 64'd2);
        chk("rp_g2_data",  64'(fifo_data), 64'h0300_0000);
        tick();
        p_en = '0;
        chk("rp_wr2",      64'(wr_q.size() - base), 64'd2);
        chk("rp_wr2_data", 64'(wr_q[base+1]), 64'h0300_0000);
        p_len[0] = 0; p_len[2] = 0;

        // Round-robin with continuous demand: 16 beats in 20 cycles.
        do_reset();
        p_en = 4'b1111;
        base = wr_q.size();
        for (int k = 0; k < NR; k++) begin
            tick();
            chk($sformatf("rr_gid%0d", k), 64'(grant_id), 64'(k));
            chk($sformatf("rr_busy%0d", k), 64'(busy), 64'd1);
            repeat (MB) tick();
            chk($sformatf("rr_gap%0d", k), 64'(busy), 64'd0);
        end
        chk("rr_count", 64'(wr_q.size() - base), 64'd16);
        for (int k = 0; k < NR; k++)
            for (int j = 0; j < MB; j++)
                chk($sformatf("rr_d%0d_%0d", k, j), 64'(wr_q[base + k*MB + j]),
                    64'({8'(k + 1), 24'(j)}));
        tick();
        chk("rr_wrap_gid", 64'(grant_id), 64'd0);
        p_en = '0;
        tick();

        // FIFO backpressure mid-burst.
        do_reset();
        p_en = 4'b0010;
        base = wr_q.size();
        tick();
        tick();
        fifo_ready = 1'b0;
        #1;
        chk("bp_ready", 64'(req_ready), 64'd0);
        chk("bp_data",  64'(fifo_data), 64'h0200_0001);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("bp_hold_gid%0d", c), 64'(grant_id), 64'd1);
            chk($sformatf("bp_hold_busy%0d", c), 64'(busy), 64'd1);
            chk($sformatf("bp_hold_data%0d", c), 64'(fifo_data), 64'h0200_0001);
        end
        chk("bp_stall_cnt", 64'(wr_q.size() - base), 64'd1);
        fifo_ready = 1'b1;
        tick();
        tick();
        chk("bp_still_busy", 64'(busy), 64'd1);
        tick();
        p_en = '0;
        chk("bp_release", 64'(busy), 64'd0);
        chk("bp_count",   64'(wr_q.size() - base), 64'd4);
        for (int j = 0; j < MB; j++)
            chk($sformatf("bp_d%0d", j), 64'(wr_q[base + j]), 64'({8'd2, 24'(j)}));

        // Almost-full gating in IDLE; no effect on an active burst.
        do_reset();
        p_len[1] = 2;
        fifo_af = 1'b1;
        p_en = 4'b0010;
        base = wr_q.size();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("af_hold%0d", c), 64'(busy), 64'd0);
        end
        fifo_af = 1'b0;
        tick();
        chk("af_grant_busy", 64'(busy), 64'd1);
        chk("af_grant_gid",  64'(grant_id), 64'd1);
        fifo_af = 1'b1;
        tick();
        chk("af_mid_busy", 64'(busy), 64'd1);
        tick();
        chk("af_done",  64'(busy), 64'd0);
        chk("af_count", 64'(wr_q.size() - base), 64'd2);
        tick();
        chk("af_regate", 64'(busy), 64'd0);
        fifo_af = 1'b0;
        p_en = '0;
        p_len[1] = 0;

        // Withdraw: producer 3 drops valid in its second burst cycle.
        do_reset();
        p_en = 4'b1000;
        base = wr_q.size();
        tick();
        chk("wd_gid3", 64'(grant_id), 64'd3);
        tick();
        p_en = 4'b0110;
        #1 chk("wd_valid", 64'(fifo_valid), 64'd0);
        tick();
        chk("wd_idle",  64'(busy), 64'd0);
        chk("wd_count", 64'(wr_q.size() - base), 64'd1);
        tick();
        chk("wd_next_gid", 64'(grant_id), 64'd1);
        p_en = '0;
        tick();

        // Asynchronous reset during a stalled burst.
        do_reset();
        p_en = 4'b0001;
        tick();
        tick();
        fifo_ready = 1'b0;
        base = wr_q.size();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy",  64'(busy), 64'd0);
        chk("ar_valid", 64'(fifo_valid), 64'd0);
        chk("ar_ready", 64'(req_ready), 64'd0);
        chk("ar_data",  64'(fifo_data), 64'd0);
        fifo_ready = 1'b1;
        p_en = 4'b0011;
        tick();
        rst_n = 1'b1;
        chk("ar_wr_unchanged", 64'(wr_q.size() - base), 64'd0);
        tick();
        chk("ar_post_gid", 64'(grant_id), 64'd0);
        p_en = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
